// File: rtl/bj_pkg.sv
// Types and constants shared by the blackjack datapath blocks.
package bj_pkg;
    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;

    typedef logic [5:0] card_idx_t;
    typedef logic [3:0] card_val_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROBE,
        ST_PRESENT
    } dealer_state_t;
endpackage

// File: rtl/card_value_map.sv
// Deck index to blackjack value: rank = index mod 13, ace = 1, faces = 10.
module card_value_map
    import bj_pkg::*;
(
    input  card_idx_t idx,
    output card_val_t value
);
    card_idx_t rank;

    always_comb begin
        rank = idx;
        if (idx >= 6'(3 * RANKS))      rank = idx - 6'(3 * RANKS);
        else if (idx >= 6'(2 * RANKS)) rank = idx - 6'(2 * RANKS);
        else if (idx >= 6'(RANKS))     rank = idx - 6'(RANKS);

        if (rank == 6'd0)       value = 4'd1;
        else if (rank <= 6'd9)  value = rank[3:0] + 4'd1;
        else                    value = 4'd10;
    end
endmodule

// File: rtl/card_dealer.sv
// Draws cards without replacement from a 52-card bitmap; an LFSR picks the
// start index and collisions are resolved by linear probing.
module card_dealer
    import bj_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shuffle,
    input  logic       draw_req,
    output logic [3:0] card_value,
    output logic [5:0] card_index,
    output logic       card_ready,
    output logic [5:0] cards_left,
    output logic       deck_empty,
    output logic       busy
);
    dealer_state_t          state;
    logic [15:0]            lfsr;
    logic [15:0]            lfsr_next;
    logic [DECK_SIZE-1:0]   used;
    card_idx_t              cand;
    card_idx_t              start;
    card_val_t              cand_val;

    // Galois form of x^16+x^14+x^13+x^11, shifting right.
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign start     = (lfsr[5:0] >= 6'(DECK_SIZE)) ? lfsr[5:0] - 6'(DECK_SIZE) : lfsr[5:0];

    card_value_map u_map (
        .idx   (cand),
        .value (cand_val)
    );

    assign card_ready = (state == ST_PRESENT);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            lfsr       <= LFSR_SEED;
            used       <= '0;
            cand       <= '0;
            card_index <= '0;
            card_value <= '0;
            cards_left <= 6'(DECK_SIZE);
            deck_empty <= 1'b0;
        end else begin
            // The LFSR keeps running regardless of state so request timing adds entropy.
            lfsr <= lfsr_next;
            if (shuffle) begin
                state      <= ST_IDLE;
                used       <= '0;
                cards_left <= 6'(DECK_SIZE);
                deck_empty <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (draw_req && !deck_empty) begin
                            cand  <= start;
                            state <= ST_PROBE;
                        end
                    end
                    ST_PROBE: begin
                        if (!used[cand]) begin
                            used[cand] <= 1'b1;
                            card_index <= cand;
                            card_value <= cand_val;
                            cards_left <= cards_left - 6'd1;
                            deck_empty <= (cards_left == 6'd1);
                            state      <= ST_PRESENT;
                        end else begin
                            cand <= (cand == 6'(DECK_SIZE - 1)) ? 6'd0 : cand + 6'd1;
                        end
                    end
                    ST_PRESENT: state <= ST_IDLE;
                    default:    state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: cycle table on a fresh deck plus full-deck,
// empty-deck and reset-abort sequences.
module tb_card_dealer;
    logic       clk = 1'b0;
    logic       rst;
    logic       shuffle;
    logic       draw_req;
    logic [3:0] card_value;
    logic [5:0] card_index;
    logic       card_ready;
    logic [5:0] cards_left;
    logic       deck_empty;
    logic       busy;

    int total = 0;
    int bad   = 0;

    card_dealer #(.LFSR_SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst        (rst),
        .shuffle    (shuffle),
        .draw_req   (draw_req),
        .card_value (card_value),
        .card_index (card_index),
        .card_ready (card_ready),
        .cards_left (cards_left),
        .deck_empty (deck_empty),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sh;
        logic       dr;
        logic       ready;
        logic       bsy;
        logic [5:0] left;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_val(input int i);
        int r;
        r = i % 13;
        if (r == 0) return 1;
        if (r <= 9) return r + 1;
        return 10;
    endfunction

    initial begin
        bit seen[52];
        int val_of[52];
        int hist[11];
        int lat;
        int strobes;
        int idx;

        rst = 1'b0; shuffle = 1'b0; draw_req = 1'b0;
        tick(); tick();
        chk("reset cards_left", cards_left, 52);
        chk("reset deck_empty", deck_empty, 0);
        chk("reset busy",       busy, 0);
        chk("reset card_ready", card_ready, 0);
        chk("reset card_value", card_value, 0);
        chk("reset card_index", card_index, 0);
        rst = 1'b1;
        tick();
        chk("post-reset cards_left", cards_left, 52);
        chk("post-reset busy", busy, 0);

        // Each row: inputs applied before an edge, outputs expected after it.
        // Every draw starts from a full deck so the first probe always hits.
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd52}; // accept -> PROBE
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd51}; // PRESENT strobe
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd51}; // back to IDLE
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd52}; // shuffle refills
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd52}; // accept
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd52}; // shuffle aborts PROBE
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd52}; // no late strobe
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd52}; // shuffle beats draw_req
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd52}; // accept
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd51}; // req while busy ignored
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd51}; // req in PRESENT ignored
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd51}; // nothing queued
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd52}; // shuffle
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd52}; // accept
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd51}; // PRESENT strobe
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd52}; // shuffle returns that card

        for (int v = 0; v < 16; v++) begin
            shuffle  = vecs[v].sh;
            draw_req = vecs[v].dr;
            tick();
            chk($sformatf("vec%0d card_ready", v), card_ready, vecs[v].ready);
            chk($sformatf("vec%0d busy", v), busy, vecs[v].bsy);
            chk($sformatf("vec%0d cards_left", v), cards_left, vecs[v].left);
            chk($sformatf("vec%0d deck_empty", v), deck_empty, 0);
            if (card_ready)
                chk($sformatf("vec%0d value map", v), card_value, ref_val(card_index));
        end
        shuffle = 1'b0; draw_req = 1'b0;
        tick();

        // Full deck: 52 draws, checked against an independent rank model.
        for (int i = 0; i < 52; i++) seen[i] = 1'b0;
        for (int v = 0; v < 11; v++) hist[v] = 0;
        for (int k = 0; k < 52; k++) begin
            draw_req = 1'b1;
            tick();
            draw_req = 1'b0;
            lat = 1;
            while (!card_ready && lat < 60) begin
                tick();
                lat++;
            end
            if (!card_ready) begin
                chk($sformatf("draw%0d timeout", k), 0, 1);
                tick();
                continue;
            end
            chk($sformatf("draw%0d latency ok", k), int'(lat >= 2 && lat <= 53), 1);
            idx = card_index;
            chk($sformatf("draw%0d index range", k), int'(idx < 52), 1);
            if (idx < 52) begin
                chk($sformatf("draw%0d distinct", k), seen[idx], 0);
                seen[idx] = 1'b1;
                val_of[idx] = card_value;
                chk($sformatf("draw%0d value", k), card_value, ref_val(idx));
                if (card_value <= 10) hist[card_value]++;
            end
            chk($sformatf("draw%0d cards_left", k), cards_left, 51 - k);
            tick();
            chk($sformatf("draw%0d strobe width", k), card_ready, 0);
        end
        chk("full deck_empty", deck_empty, 1);
        chk("full cards_left", cards_left, 0);
        for (int v = 1; v <= 9; v++)
            chk($sformatf("hist value %0d", v), hist[v], 4);
        chk("hist value 10", hist[10], 16);
        chk("map idx0",  val_of[0],  1);
        chk("map idx8",  val_of[8],  9);
        chk("map idx9",  val_of[9],  10);
        chk("map idx12", val_of[12], 10);
        chk("map idx13", val_of[13], 1);
        chk("map idx51", val_of[51], 10);

        // 53rd request on an empty deck must be dropped.
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        strobes = 0;
        for (int c = 0; c < 60; c++) begin
            if (card_ready) strobes++;
            tick();
        end
        chk("empty deck strobes", strobes, 0);
        chk("empty deck busy", busy, 0);

        // Reset mid-draw: no strobe, deck restored, outputs cleared.
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        chk("mid-draw busy before reset", busy, 1);
        rst = 1'b0;
        tick();
        chk("reset abort card_ready", card_ready, 0);
        chk("reset abort busy", busy, 0);
        chk("reset abort cards_left", cards_left, 52);
        chk("reset abort card_value", card_value, 0);
        rst = 1'b1;
        strobes = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (card_ready) strobes++;
        end
        chk("reset abort late strobe", strobes, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
